// File: rtl/alu_pkg.sv
// Shared ALU issue-stage definitions: ALU codes, RV32I opcodes,
// branch funct3 values and operand/forward select encodings.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_ctr_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_EX_MEM  = 2'b01,
        FWD_MEM_WB  = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'b00,
        OP1_PC   = 2'b01,
        OP1_ZERO = 2'b10
    } op1_sel_e;

    typedef enum logic [1:0] {
        OP2_RS2  = 2'b00,
        OP2_IMM  = 2'b01,
        OP2_FOUR = 2'b10,
        OP2_ZERO = 2'b11
    } op2_sel_e;

endpackage

// File: rtl/alu_issue_stage_dec.sv
// Combinational RV32I decode: opcode/funct -> ALU code,
// operand selects, branch and illegal flags.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] ctr,
    output logic [1:0] op1_sel,
    output logic [1:0] op2_sel,
    output logic       is_branch,
    output logic       illegal
);

    always_comb begin
        ctr       = ALU_ADD;
        op1_sel   = OP1_RS1;
        op2_sel   = OP2_RS2;
        is_branch = 1'b0;
        illegal   = 1'b0;
        unique case (1'b1)
            (opcode == OPC_OP): begin
                ctr = {funct7b5, funct3};
            end
            (opcode == OPC_OPIMM): begin
                // only SRAI uses bit 30; ADDI must stay ADD
                ctr     = {(funct3 == 3'b101) & funct7b5, funct3};
                op2_sel = OP2_IMM;
            end
            (opcode == OPC_BRANCH): begin
                is_branch = 1'b1;
                case (funct3)
                    F3_BEQ, F3_BNE:   ctr = ALU_SUB;
                    F3_BLT, F3_BGE:   ctr = ALU_SLT;
                    F3_BLTU, F3_BGEU: ctr = ALU_SLTU;
                    default: begin
                        is_branch = 1'b0;
                        illegal   = 1'b1;
                        op1_sel   = OP1_ZERO;
                        op2_sel   = OP2_ZERO;
                    end
                endcase
            end
            (opcode == OPC_LOAD),
            (opcode == OPC_STORE),
            (opcode == OPC_JALR): begin
                op2_sel = OP2_IMM;
            end
            (opcode == OPC_LUI): begin
                op1_sel = OP1_ZERO;
                op2_sel = OP2_IMM;
            end
            (opcode == OPC_AUIPC): begin
                op1_sel = OP1_PC;
                op2_sel = OP2_IMM;
            end
            (opcode == OPC_JAL): begin
                op1_sel = OP1_PC;
                op2_sel = OP2_FOUR;
            end
            default: begin
                illegal = 1'b1;
                op1_sel = OP1_ZERO;
                op2_sel = OP2_ZERO;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decode, operand select, one-entry output buffer.
// Optional operand forwarding enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CTR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  imm,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  op1,
    output logic [XLEN-1:0]  op2,
    output logic [CTR_W-1:0] alu_ctr,
    output logic [4:0]       rd,
    output logic             is_branch,
    output logic [2:0]       br_funct3,
    output logic             illegal,
    input  logic [1:0]       fwd_a_sel,
    input  logic [1:0]       fwd_b_sel,
    input  logic [XLEN-1:0]  ex_mem_result,
    input  logic [XLEN-1:0]  mem_wb_result
);

    logic [3:0]      dec_ctr;
    logic [1:0]      dec_op1_sel;
    logic [1:0]      dec_op2_sel;
    logic            dec_branch;
    logic            dec_illegal;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] op1_nxt;
    logic [XLEN-1:0] op2_nxt;
    logic            accept;
    logic            unused_inst;

    assign unused_inst = ^{inst[31], inst[29:15]};

    alu_ctrl_dec u_dec (
        .opcode    (inst[6:0]),
        .funct3    (inst[14:12]),
        .funct7b5  (inst[30]),
        .ctr       (dec_ctr),
        .op1_sel   (dec_op1_sel),
        .op2_sel   (dec_op2_sel),
        .is_branch (dec_branch),
        .illegal   (dec_illegal)
    );

`ifdef ALU_ISSUE_FWD_EN
    always_comb begin
        case (fwd_a_sel)
            FWD_EX_MEM: src_a = ex_mem_result;
            FWD_MEM_WB: src_a = mem_wb_result;
            default:    src_a = rs1_data;
        endcase
        case (fwd_b_sel)
            FWD_EX_MEM: src_b = ex_mem_result;
            FWD_MEM_WB: src_b = mem_wb_result;
            default:    src_b = rs2_data;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_a_sel, fwd_b_sel,
                          ex_mem_result, mem_wb_result};
    assign src_a = rs1_data;
    assign src_b = rs2_data;
`endif

    always_comb begin
        case (dec_op1_sel)
            OP1_PC:   op1_nxt = pc;
            OP1_ZERO: op1_nxt = '0;
            default:  op1_nxt = src_a;
        endcase
        case (dec_op2_sel)
            OP2_IMM:  op2_nxt = imm;
            OP2_FOUR: op2_nxt = XLEN'(4);
            OP2_ZERO: op2_nxt = '0;
            default:  op2_nxt = src_b;
        endcase
    end

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            op1       <= '0;
            op2       <= '0;
            alu_ctr   <= '0;
            rd        <= '0;
            is_branch <= 1'b0;
            br_funct3 <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            op1       <= op1_nxt;
            op2       <= op2_nxt;
            alu_ctr   <= CTR_W'(dec_ctr);
            rd        <= inst[11:7];
            is_branch <= dec_branch;
            br_funct3 <= inst[14:12];
            illegal   <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios
// plus randomized traffic against a behavioural reference model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  alu_ctr;
    logic [4:0]  rd;
    logic        is_branch;
    logic [2:0]  br_funct3;
    logic        illegal;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [31:0] ex_mem_result;
    logic [31:0] mem_wb_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .inst          (inst),
        .pc            (pc),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .imm           (imm),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .op1           (op1),
        .op2           (op2),
        .alu_ctr       (alu_ctr),
        .rd            (rd),
        .is_branch     (is_branch),
        .br_funct3     (br_funct3),
        .illegal       (illegal),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel),
        .ex_mem_result (ex_mem_result),
        .mem_wb_result (mem_wb_result)
    );

    typedef struct packed {
        logic [3:0]  ctr;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        br;
        logic [2:0]  f3;
        logic        ill;
    } exp_t;

    logic [77:0] act;
    assign act = {alu_ctr, op1, op2, rd, is_branch, br_funct3, illegal};

    localparam logic [6:0] OPCS [10] = '{
        7'h33, 7'h13, 7'h63, 7'h03, 7'h23,
        7'h67, 7'h37, 7'h17, 7'h6F, 7'h7F
    };

    function automatic logic [31:0] fwd_val(input logic [1:0] sel,
        input logic [31:0] r, input logic [31:0] x, input logic [31:0] m);
`ifdef ALU_ISSUE_FWD_EN
        if (sel == 2'b01) return x;
        if (sel == 2'b10) return m;
        return r;
`else
        return r;
`endif
    endfunction

    // Instruction semantics: what each RV32I class feeds the ALU.
    function automatic exp_t ref_model(input logic [31:0] i,
        input logic [31:0] p, input logic [31:0] ra,
        input logic [31:0] rb, input logic [31:0] im);
        exp_t e;
        logic [2:0] f3;
        f3 = i[14:12];
        e = '0;
        e.rd = i[11:7];
        e.f3 = f3;
        case (i[6:0])
            7'h33: begin
                e.ctr = {i[30], f3};
                e.a = ra; e.b = rb;
            end
            7'h13: begin
                e.ctr = (f3 == 3'd5) ? {i[30], f3} : {1'b0, f3};
                e.a = ra; e.b = im;
            end
            7'h63: begin
                if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
                else begin
                    e.br = 1'b1;
                    e.a = ra; e.b = rb;
                    if (f3 < 3'd4) e.ctr = 4'b1000;
                    else if (f3 < 3'd6) e.ctr = 4'b0010;
                    else e.ctr = 4'b0011;
                end
            end
            7'h03, 7'h23, 7'h67: begin e.a = ra; e.b = im; end
            7'h37: begin e.a = 32'd0; e.b = im; end
            7'h17: begin e.a = p; e.b = im; end
            7'h6F: begin e.a = p; e.b = 32'd4; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic drive(input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im);
        inst = i; rs1_data = a; rs2_data = b; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({out_valid, act} !== 79'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_init got %h rdy %b want 0 rdy 1",
                     {out_valid, act}, in_ready);
        end
        reset = 1'b0;
        out_ready = 1'b0;
        drive(32'h002081B3, 32'd5, 32'd3, 32'd0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_pre got v=%b rdy=%b want v=1 rdy=0",
                     out_valid, in_ready);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, act} !== 79'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_async got %h rdy %b want 0 rdy 1",
                     {out_valid, act}, in_ready);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        out_ready = 1'b1;
        drive(32'h002081B3, 32'd5, 32'd3, 32'd0);
        tick();
        e = '{4'h0, 32'd5, 32'd3, 5'd3, 1'b0, 3'd0, 1'b0};
        checks++;
        if (act !== e || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL add got %h v %b want %h", act, out_valid, e);
        end
        drive(32'h402081B3, 32'd5, 32'd3, 32'd0);
        tick();
        e = '{4'h8, 32'd5, 32'd3, 5'd3, 1'b0, 3'd0, 1'b0};
        checks++;
        if (act !== e || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sub got %h v %b want %h", act, out_valid, e);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_shift_imm();
        exp_t e;
        out_ready = 1'b1;
        drive(32'h4030D093, 32'h80000000, 32'd9, 32'd3);
        tick();
        e = '{4'hD, 32'h80000000, 32'd3, 5'd1, 1'b0, 3'd5, 1'b0};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL srai got %h want %h", act, e);
        end
        drive(32'h0030D093, 32'h80000000, 32'd9, 32'd3);
        tick();
        e.ctr = 4'h5;
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL srli got %h want %h", act, e);
        end
        drive(32'h40308093, 32'd7, 32'd9, 32'h403);
        tick();
        e = '{4'h0, 32'd7, 32'h403, 5'd1, 1'b0, 3'd0, 1'b0};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL addi_b30 got %h want %h", act, e);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(32'h002081B3, 32'd11, 32'd22, 32'd0);
        tick();
        drive(32'h402081B3, 32'd33, 32'd44, 32'd0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                {alu_ctr, op1, op2} !== {4'h0, 32'd11, 32'd22}) begin
                errors++;
                $display("FAIL stall%0d got rdy=%b v=%b %h %h %h",
                         k, in_ready, out_valid, alu_ctr, op1, op2);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_rdy got %b want 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 ||
            {alu_ctr, op1, op2} !== {4'h8, 32'd33, 32'd44}) begin
            errors++;
            $display("FAIL release got v=%b %h %h %h want 8 21 2c",
                     out_valid, alu_ctr, op1, op2);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(32'h123450B7, 32'd1, 32'd2, 32'h12345000);
        tick();
        drive(32'h002081B3, 32'd5, 32'd3, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush got v=%b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop got v=%b want 0", out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_branch_illegal();
        exp_t e;
        out_ready = 1'b1;
        drive(32'h0020E063, 32'd7, 32'd9, 32'd0);
        tick();
        e = '{4'h3, 32'd7, 32'd9, 5'd0, 1'b1, 3'b110, 1'b0};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL bltu got %h want %h", act, e);
        end
        drive(32'h0000007F, 32'd7, 32'd9, 32'd5);
        tick();
        e = '{4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 3'b000, 1'b1};
        checks++;
        if (act !== e || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL opc7f got %h v %b want %h", act, out_valid, e);
        end
        drive(32'h00202063, 32'd7, 32'd9, 32'd5);
        tick();
        e = '{4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 3'b010, 1'b1};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL br_f3_010 got %h want %h", act, e);
        end
        pc = 32'h100;
        drive(32'h0000006F, 32'd7, 32'd9, 32'd5);
        tick();
        e = '{4'h0, 32'h100, 32'd4, 5'd0, 1'b0, 3'b000, 1'b0};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL jal got %h want %h", act, e);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        logic [31:0] ea;
        logic [31:0] eb;
        out_ready = 1'b1;
        fwd_a_sel = 2'b01; fwd_b_sel = 2'b10;
        ex_mem_result = 32'hDEAD; mem_wb_result = 32'hBEEF;
        drive(32'h002081B3, 32'd5, 32'd3, 32'd0);
        tick();
`ifdef ALU_ISSUE_FWD_EN
        ea = 32'hDEAD; eb = 32'hBEEF;
`else
        ea = 32'd5; eb = 32'd3;
`endif
        checks++;
        if (op1 !== ea || op2 !== eb) begin
            errors++;
            $display("FAIL fwd_op got %h %h want %h %h",
                     op1, op2, ea, eb);
        end
        drive(32'h123450B7, 32'd5, 32'd3, 32'h12345000);
        tick();
        checks++;
        if (op1 !== 32'd0 || op2 !== 32'h12345000) begin
            errors++;
            $display("FAIL fwd_lui got %h %h want 0 12345000", op1, op2);
        end
        in_valid = 1'b0;
        fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
        tick();
    endtask

    task automatic test_random();
        exp_t        m_entry;
        logic        m_valid;
        logic [31:0] r;
        m_valid = out_valid;
        m_entry = '0;
        for (int n = 0; n < 400; n++) begin
            checks++;
            if (out_valid !== m_valid ||
                (m_valid && act !== m_entry)) begin
                errors++;
                $display("FAIL rand%0d got v=%b %h want v=%b %h",
                         n, out_valid, act, m_valid, m_entry);
            end
            r = $urandom;
            inst = {r[31:7], OPCS[$urandom_range(0, 9)]};
            pc = $urandom; rs1_data = $urandom;
            rs2_data = $urandom; imm = $urandom;
            ex_mem_result = $urandom; mem_wb_result = $urandom;
            fwd_a_sel = 2'($urandom); fwd_b_sel = 2'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 15) == 0);
            #1;
            checks++;
            if (in_ready !== (!m_valid || out_ready)) begin
                errors++;
                $display("FAIL rand_rdy%0d got %b want %b",
                         n, in_ready, !m_valid || out_ready);
            end
            @(posedge clk);
            if (flush) m_valid = 1'b0;
            else if (in_valid && (!m_valid || out_ready)) begin
                m_valid = 1'b1;
                m_entry = ref_model(inst, pc,
                    fwd_val(fwd_a_sel, rs1_data, ex_mem_result,
                            mem_wb_result),
                    fwd_val(fwd_b_sel, rs2_data, ex_mem_result,
                            mem_wb_result),
                    imm);
            end else if (out_ready) m_valid = 1'b0;
            #1;
        end
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        inst = '0; pc = '0; rs1_data = '0; rs2_data = '0; imm = '0;
        fwd_a_sel = '0; fwd_b_sel = '0;
        ex_mem_result = '0; mem_wb_result = '0;
        test_reset();
        test_back_to_back();
        test_shift_imm();
        test_backpressure();
        test_flush();
        test_branch_illegal();
        test_forward();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage sitting on the producing side of the execute-stage ALU.
- Decodes a 32-bit RV32I instruction into the 4-bit ALU control code and selects the operands: rs1 or pc, rs2 or imm.
- Registers the result into a single-entry pipeline buffer, handshaked valid/ready on both sides.
- Drives op1/op2/alu_ctr of the ALU directly; pipeline control (stall and flush) arrives from hazard logic.

Parameters:
- XLEN, 32, datapath width of pc, register operands, imm, op1 and op2.
- CTR_W, 4, width of alu_ctr.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- inst  in  32  instruction word.
- pc  in  XLEN  instruction address.
- rs1_data  in  XLEN  register-file read port A.
- rs2_data  in  XLEN  register-file read port B.
- imm  in  XLEN  sign-extended immediate from the imm generator.
- flush  in  1  squash the held entry and any accepting input.
- out_valid  out  1  buffered entry is valid.
- out_ready  in  1  execute stage consumes the entry.
- op1  out  XLEN  ALU operand 1.
- op2  out  XLEN  ALU operand 2.
- alu_ctr  out  CTR_W  ALU operation code.
- rd  out  5  destination register (inst[11:7]).
- is_branch  out  1  entry is a conditional branch.
- br_funct3  out  3  funct3 for branch resolution.
- illegal  out  1  entry opcode not decoded.
- fwd_a_sel, fwd_b_sel  in  2 each  forward select: 00 reg, 01 ex_mem_result, 10 mem_wb_result, 11 reg.
- ex_mem_result, mem_wb_result  in  XLEN each  forwarding data.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0; op1, op2, alu_ctr, rd, br_funct3 = 0; is_branch=0; illegal=0.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational).
  - Capture on in_valid & in_ready & ~flush.
  - Latency 1 cycle: inst accepted at edge N is visible on the outputs after edge N.
  - Entry holds stable while out_valid & ~out_ready.
  - Fire at clock edge, with no capture: out_valid falls to 0.
- Flush is synchronous and has priority over everything: out_valid->0 and the input is not captured, even if in_valid=1. Data registers may keep stale values.
- alu_ctr decode, by opcode:
  - OP (0110011): {funct7[5], funct3}.
  - OP-IMM (0010011): {funct3==101 ? funct7[5] : 0, funct3}. ADDI never decodes as SUB.
  - BRANCH (1100011): funct3 000/001 -> 1000 (SUB); 100/101 -> 0010 (SLT); 110/111 -> 0011 (SLTU).
  - LOAD, STORE, JAL, JALR, AUIPC, LUI: 0000 (ADD).
- Codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- Operand selection:
  - op1: pc for AUIPC/JAL; 0 for LUI; otherwise rs1.
  - op2: imm for OP-IMM, LOAD, STORE, LUI, AUIPC, JALR; 4 for JAL; otherwise rs2.
- Unknown opcode or funct3 (e.g. BRANCH funct3 010): illegal=1, alu_ctr=0000, op1=op2=0, is_branch=0. The entry still flows through the handshake.
- is_branch=1 only for BRANCH; br_funct3 = funct3.
- Widths: all operands are XLEN; no extension inside this block.

Optional Feature:
- Macro ALU_ISSUE_FWD_EN.
- Defined: rs1/rs2 are replaced by the forwarding mux output chosen by fwd_a_sel/fwd_b_sel before operand selection. Forwarding applies only where the register value is used; pc, imm, 0 and 4 are never forwarded.
- Undefined: the fwd_* and *_result ports are present but ignored; register data is used directly.

Decomposition:
- Package alu_pkg holds:
  - the alu_ctr enum (ALU_ADD ... ALU_AND, 4 bits);
  - RV32I opcode constants;
  - branch funct3 constants;
  - the fwd_sel enum.
- One sub-module, alu_ctrl_dec: combinational opcode/funct -> alu_ctr, op1/op2 select, illegal, is_branch. The top level holds the muxes and the pipeline register.

Test Plan:
- Reset mid-stream: assert reset with out_valid=1 -> all outputs 0 immediately (asynchronous), in_ready=1.
- ADD then SUB back-to-back with out_ready=1:
  - inst=0x002081B3, rs1=5, rs2=3 -> next cycle alu_ctr=0000, op1=5, op2=3, rd=3.
  - inst=0x402081B3 -> alu_ctr=1000.
- SRAI vs SRLI:
  - inst=0x4030D093 -> alu_ctr=1101, op2=imm=3.
  - inst=0x0030D093 -> alu_ctr=0101.
  - ADDI with inst[30]=1 -> alu_ctr=0000.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable. out_ready=1 -> next instruction captured the following edge.
- Flush with simultaneous in_valid=1, out_valid=1 -> out_valid=0 next cycle, input dropped.
- BLTU (funct3 110) -> alu_ctr=0011, is_branch=1, br_funct3=110. Opcode 0x7F -> illegal=1, alu_ctr=0000.
- With ALU_ISSUE_FWD_EN: fwd_a_sel=01, ex_mem_result=0xDEAD -> op1=0xDEAD for an OP instruction.
